debounced_edge_detector: RTL
============================

DEBOUNCED_EDGE_DETECTOR -- requirements
Module: debounced_edge_detector

Interface
REQ-001 Parameter CH, 4, number of independent input channels (>=1).
REQ-002 Parameter SYNC_STAGES, 2, synchronizer flops per channel (>=2).
REQ-003 Parameter STARTUP_CYCLES, 200, post-reset blanking cycles (>=0).
REQ-004 Parameter DEBOUNCE_CYCLES, 16, consecutive differing cycles required to accept a level change (>=1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 signal  input  CH  raw asynchronous inputs.
REQ-008 ch_en  input  CH  per-channel enable.
REQ-009 mode  input  2  event-flag qualifier: 00 rising, 01 falling, 10 both, 11 none.
REQ-010 event_clr  input  CH  per-channel sticky-flag clear.
REQ-011 ready  output  1  blanking period complete.
REQ-012 level  output  CH  debounced channel level.
REQ-013 raising_edge_detect  output  CH  one-cycle pulse on accepted 0->1.
REQ-014 falling_edge_detect  output  CH  one-cycle pulse on accepted 1->0.
REQ-015 double_edge_detect  output  CH  one-cycle pulse on any accepted change.
REQ-016 event_flag  output  CH  sticky qualified-edge flag.

Function
REQ-017 Startup counter SHALL count from 0 after reset release, saturate, and drive ready=1 once STARTUP_CYCLES edges have elapsed; with STARTUP_CYCLES=0, ready SHALL be 1 after the first rising edge following reset release.
REQ-018 Each channel SHALL pass signal through SYNC_STAGES flops; the last stage is the synchronized value s.
REQ-019 While ready=0 or ch_en=0, a channel SHALL load level<=s every cycle, hold its debounce counter at 0, and generate no edge pulses and no flag sets.
REQ-020 While ready=1 and ch_en=1: if s==level, counter<=0; if s!=level and counter==DEBOUNCE_CYCLES-1, level<=s and counter<=0; otherwise counter increments.
REQ-021 Edge outputs SHALL be registered and high for exactly the one cycle in which level first shows its new value; double_edge_detect = raising OR falling.
REQ-022 Latency: a clean input change SHALL appear on level and the edge pulses after SYNC_STAGES+DEBOUNCE_CYCLES rising edges, counted from the first edge that samples the new value.
REQ-023 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no level change and no pulse.
REQ-024 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); startup counter width SHALL be $clog2(STARTUP_CYCLES+1), minimum 1; no wrap permitted.
REQ-025 event_flag[i] SHALL set on a pulse qualified by mode and clear on event_clr[i]; simultaneous set and clear SHALL leave it set.
REQ-026 A mode change SHALL affect only edges accepted on or after the cycle of the change; existing flags SHALL be retained.
REQ-027 Re-enabling a channel SHALL produce no pulse, even when level changes during the load.

Reset
REQ-028 rst_n low SHALL immediately clear every synchronizer flop, debounce counter, startup counter, level, edge output, event_flag and ready to 0.
REQ-029 Reset asserted mid-debounce or mid-startup SHALL abandon all progress; blanking restarts from 0 on release.

Structure
REQ-030 Mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_NONE) SHALL live in shared package edge_det_pkg.
REQ-031 Per-channel logic (synchronizer, debounce counter, level, edge pulses, flag) SHALL be sub-module edge_det_channel, generated CH times; the startup counter SHALL reside in the top level.
REQ-032 Illegal parameter values SHALL fail elaboration.

Verification (CH=4, SYNC_STAGES=2, STARTUP_CYCLES=200, DEBOUNCE_CYCLES=16)
REQ-033 signal[0]=1 held through reset release -> ready rises after 200 edges, level[0]=1, no raising_edge_detect[0] pulse at any time.
REQ-034 After ready, signal[1] 0->1 held stable -> level[1], raising_edge_detect[1] and double_edge_detect[1] change 18 edges later; both pulses last exactly 1 cycle.
REQ-035 After ready, signal[2] high for 10 cycles then low -> level[2] stays 0, no pulses; held high for 16 synchronized cycles -> change accepted.
REQ-036 mode=01 on ch3: rise -> event_flag[3] stays 0; fall -> event_flag[3]=1; event_clr[3] coincident with the next fall -> flag remains 1; event_clr[3] alone -> 0 next cycle.
REQ-037 ch_en[0]=0 while signal[0] toggles every 30 cycles -> level[0] follows the synchronized input with no pulses; re-enable -> no pulse.
REQ-038 rst_n pulsed low at debounce count 8 on ch1 -> all outputs 0 without waiting for clk; after release, ready returns only after a full 200 edges.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared definitions for the debounced edge detector: event-flag mode encodings
// and the edge qualification rule used by every channel.
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } mode_t;

  function automatic logic edge_qualifies(input mode_t mode, input logic rise, input logic fall);
    return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
           (fall && (mode == MODE_FALL || mode == MODE_BOTH));
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One input channel: synchronizer, debounce counter, accepted level,
// registered edge pulses and a sticky mode-qualified event flag.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  signal,
  input  logic  ch_en,
  input  logic  ready,
  input  mode_t mode,
  input  logic  event_clr,
  output logic  level,
  output logic  raising,
  output logic  falling,
  output logic  double_edge,
  output logic  event_flag
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "edge_det_channel: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $fatal(1, "edge_det_channel: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0]          cnt;
  logic                   s;
  logic                   active;
  logic                   accept;
  logic                   set_flag;

  always_comb begin
    s        = sync[SYNC_STAGES-1];
    active   = ready && ch_en;
    accept   = active && (s != level) && (cnt == CNT_LAST);
    set_flag = edge_qualifies(mode, accept && s, accept && !s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      raising    <= 1'b0;
      falling    <= 1'b0;
      event_flag <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], signal};
      raising    <= accept && s;
      falling    <= accept && !s;
      event_flag <= set_flag || (event_flag && !event_clr);
      // Blanked/disabled load, stable input and acceptance all reduce to level<=s, cnt<=0.
      if (!active || (s == level) || accept) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  assign double_edge = raising | falling;

endmodule

// File: rtl/debounced_edge_detector.sv
// Multi-channel debounced edge detector: post-reset blanking counter plus
// CH independent edge_det_channel instances sharing mode and ready.
module debounced_edge_detector
  import edge_det_pkg::*;
#(
  parameter int CH              = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int STARTUP_CYCLES  = 200,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] signal,
  input  logic [CH-1:0] ch_en,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] event_clr,
  output logic          ready,
  output logic [CH-1:0] level,
  output logic [CH-1:0] raising_edge_detect,
  output logic [CH-1:0] falling_edge_detect,
  output logic [CH-1:0] double_edge_detect,
  output logic [CH-1:0] event_flag
);

  if (CH < 1) begin : g_bad_ch
    $fatal(1, "debounced_edge_detector: CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "debounced_edge_detector: SYNC_STAGES must be >= 2");
  end
  if (STARTUP_CYCLES < 0) begin : g_bad_start
    $fatal(1, "debounced_edge_detector: STARTUP_CYCLES must be >= 0");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $fatal(1, "debounced_edge_detector: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam int unsigned SW_RAW = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned SW     = (SW_RAW < 1) ? 1 : SW_RAW;
  localparam int unsigned SW1    = SW + 1;

  logic [SW-1:0] start_cnt;
  logic          start_done;
  logic          start_hit;
  mode_t         mode_q;

  always_comb begin
    mode_q     = mode_t'(mode);
    start_done = (start_cnt == SW'(STARTUP_CYCLES));
    // ready is registered, so it is set on the edge that completes the blanking count.
    start_hit  = (STARTUP_CYCLES == 0) ||
                 (({1'b0, start_cnt} + SW1'(1)) == SW1'(STARTUP_CYCLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      if (!start_done) begin
        start_cnt <= start_cnt + SW'(1);
      end
      if (start_hit) begin
        ready <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .signal     (signal[i]),
      .ch_en      (ch_en[i]),
      .ready      (ready),
      .mode       (mode_q),
      .event_clr  (event_clr[i]),
      .level      (level[i]),
      .raising    (raising_edge_detect[i]),
      .falling    (falling_edge_detect[i]),
      .double_edge(double_edge_detect[i]),
      .event_flag (event_flag[i])
    );
  end

endmodule
